// File: rtl/ifstmt_chan_engine.sv
// ifstmt_chan_engine
// Multi-channel priority-if register engine. Each accepted operation applies a
// sel-coded update rule to one of CHANNELS register sets (buffer, data_out,
// branch_flag). Operations are captured in IDLE, applied in APPLY, and a
// sel==4'b1111 op adds a HOLD stall of HOLD_CYCLES cycles.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operation offered
//   in_ready     high only in IDLE
//   ch_sel       target channel (out-of-range channels are accepted, no effect)
//   sel          operation code
//   data_in      operand
//   data_out     per-channel result, channel k at [k*WIDTH +: WIDTH]
//   branch_flag  per-channel flag
//   out_valid    one-cycle pulse per completed op
//   busy         !in_ready
//   comb_preview combinational preview of what ch_sel/sel/data_in would give
//
// state | meaning
// IDLE  | ready, waiting for in_valid
// APPLY | captured op is written into the target channel
// HOLD  | stall after a sel==4'b1111 op, counter counts down to 1

module ifstmt_chan_engine #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 3,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CW-1:0]             ch_sel,
  input  logic [3:0]                sel,
  input  logic [WIDTH-1:0]          data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       branch_flag,
  output logic                      out_valid,
  output logic                      busy,
  output logic [WIDTH-1:0]          comb_preview
);

  localparam int CNTW = $clog2(HOLD_CYCLES + 1);

  localparam logic [WIDTH-1:0] PAT_55 = {(WIDTH/8){8'h55}};
  localparam logic [WIDTH-1:0] PAT_AA = {(WIDTH/8){8'hAA}};
  localparam logic [WIDTH-1:0] PAT_3C = {(WIDTH/8){8'h3C}};
  localparam logic [WIDTH-1:0] PAT_F0 = {(WIDTH/8){8'hF0}};
  localparam logic [WIDTH-1:0] PAT_0F = {(WIDTH/8){8'h0F}};

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  state_t              state;
  logic [CW-1:0]       op_ch;
  logic [3:0]          op_sel;
  logic [WIDTH-1:0]    op_din;
  logic [CNTW-1:0]     cnt;

  logic [WIDTH-1:0]    buf_q [CHANNELS];
  logic [WIDTH-1:0]    dat_q [CHANNELS];
  logic [CHANNELS-1:0] flag_q;

  // Old values of the captured channel; out-of-range reads as zero.
  logic [WIDTH-1:0]    cur_b, cur_d;
  logic                cur_f;
  logic [WIDTH-1:0]    nxt_b, nxt_d;
  logic                nxt_f;

  always_comb begin
    cur_b = '0;
    cur_d = '0;
    cur_f = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(op_ch) == k) begin
        cur_b = buf_q[k];
        cur_d = dat_q[k];
        cur_f = flag_q[k];
      end
    end
  end

  always_comb begin
    nxt_b = cur_b;
    nxt_d = cur_d;
    nxt_f = cur_f;
    if (op_sel[3]) begin
      nxt_b = op_din;
      nxt_d = op_din;
      nxt_f = 1'b1;
    end else if (op_sel[2:1] == 2'b10) begin
      nxt_b = ~op_din;
      nxt_d = ~op_din;
      nxt_f = 1'b0;
    end else begin
      if (op_sel[0]) begin
        nxt_b = {cur_d[WIDTH-2:0], op_din[0]};
        nxt_f = ~cur_f;
      end else begin
        nxt_b = cur_d + WIDTH'(1);
        nxt_f = 1'b0;
      end
      nxt_d = cur_b[0] ? cur_b : ~cur_b;
      if (op_sel == 4'b0000) nxt_d = PAT_AA;
    end
    // Override uses the pre-op data_out, not anything computed above.
    if (op_sel[3] && op_sel[0]) nxt_d = cur_d | PAT_55;
  end

  // Preview path works on live inputs and the current channel state.
  logic [WIDTH-1:0] pv_b;
  logic             pv_f;

  always_comb begin
    pv_b = '0;
    pv_f = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(ch_sel) == k) begin
        pv_b = buf_q[k];
        pv_f = flag_q[k];
      end
    end
  end

  always_comb begin
    comb_preview = data_in;
    if (sel[3]) begin
      comb_preview = data_in ^ PAT_3C;
    end else if (sel[2]) begin
      comb_preview = {sel, data_in[WIDTH-5:0]};
    end else begin
      case (sel[1:0])
        2'b01:   comb_preview = pv_b + WIDTH'(2);
        2'b10:   comb_preview = pv_b - WIDTH'(2);
        default: comb_preview = pv_b;
      endcase
      if (pv_f) comb_preview = comb_preview & PAT_F0;
    end
    if (!pv_f && sel == 4'b1111) comb_preview = comb_preview | PAT_0F;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_ch     <= '0;
      op_sel    <= '0;
      op_din    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      flag_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        buf_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_ch  <= ch_sel;
            op_sel <= sel;
            op_din <= data_in;
            state  <= APPLY;
          end
        end
        APPLY: begin
          out_valid <= 1'b1;
          for (int k = 0; k < CHANNELS; k++) begin
            if (int'(op_ch) == k) begin
              buf_q[k]  <= nxt_b;
              dat_q[k]  <= nxt_d;
              flag_q[k] <= nxt_f;
            end
          end
          if (op_sel == 4'b1111) begin
            cnt   <= CNTW'(HOLD_CYCLES);
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign busy        = !in_ready;
  assign branch_flag = flag_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_dout
    assign data_out[k*WIDTH +: WIDTH] = dat_q[k];
  end

endmodule

// File: tb/tb_ifstmt_chan_engine.sv
// Testbench for ifstmt_chan_engine: random and directed ops, scoreboard on
// out_valid, preview checks against an arithmetic reference model.
module tb_ifstmt_chan_engine;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int HC = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   ch_sel;
  logic [3:0]      sel;
  logic [W-1:0]    data_in;
  logic [CH*W-1:0] data_out;
  logic [CH-1:0]   branch_flag;
  logic            out_valid;
  logic            busy;
  logic [W-1:0]    comb_preview;

  // Second instance at WIDTH=16, used only for preview checks.
  logic [CW-1:0]   ch16;
  logic [3:0]      sel16;
  logic [15:0]     din16;
  logic            rdy16, ov16, busy16;
  logic [CH*16-1:0] dout16;
  logic [CH-1:0]   flg16;
  logic [15:0]     pv16;

  always #5 clk = ~clk;

  ifstmt_chan_engine #(.WIDTH(W), .CHANNELS(CH), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ch_sel(ch_sel), .sel(sel), .data_in(data_in), .data_out(data_out),
    .branch_flag(branch_flag), .out_valid(out_valid), .busy(busy),
    .comb_preview(comb_preview)
  );

  ifstmt_chan_engine #(.WIDTH(16), .CHANNELS(CH), .HOLD_CYCLES(HC)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(rdy16),
    .ch_sel(ch16), .sel(sel16), .data_in(din16), .data_out(dout16),
    .branch_flag(flg16), .out_valid(ov16), .busy(busy16),
    .comb_preview(pv16)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH*W-1:0] dout;
    logic [CH-1:0]   flg;
    int              cyc;
  } exp_t;
  exp_t q[$];

  // Reference model state, plain integers.
  int mB[CH];
  int mD[CH];
  int mF[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pat(input int b);
    int r = 0;
    for (int i = 0; i < W/8; i++) r = (r << 8) | b;
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < CH; k++) begin
      mB[k] = 0; mD[k] = 0; mF[k] = 0;
    end
    q.delete();
  endtask

  task automatic m_apply(input int ch, input int s, input int din);
    int md, b, d, f, nb, nd, nf;
    md = 1 << W;
    if (ch >= CH) return;
    b = mB[ch]; d = mD[ch]; f = mF[ch];
    if (s >= 8) begin
      nb = din; nd = din; nf = 1;
    end else if ((s / 2) % 4 == 2) begin
      nb = md - 1 - din; nd = nb; nf = 0;
    end else begin
      if (s % 2 == 1) begin
        nb = (d * 2 + din % 2) % md; nf = 1 - f;
      end else begin
        nb = (d + 1) % md; nf = 0;
      end
      nd = (b % 2 == 1) ? b : md - 1 - b;
      if (s == 0) nd = pat(8'hAA);
    end
    if (s >= 8 && s % 2 == 1) nd = d | pat(8'h55);
    mB[ch] = nb; mD[ch] = nd; mF[ch] = nf;
  endtask

  function automatic int m_preview(input int ch, input int s, input int din);
    int md, b, f, r;
    md = 1 << W;
    b = (ch < CH) ? mB[ch] : 0;
    f = (ch < CH) ? mF[ch] : 0;
    r = din;
    if (s >= 8) r = din ^ pat(8'h3C);
    else if (s >= 4) r = (s << (W - 4)) | (din % (1 << (W - 4)));
    else begin
      if (s % 4 == 1)      r = (b + 2) % md;
      else if (s % 4 == 2) r = (b - 2 + md) % md;
      else                 r = b;
      if (f != 0) r = r & pat(8'hF0);
    end
    if (f == 0 && s == 15) r = r | pat(8'h0F);
    return r;
  endfunction

  // Monitor: every out_valid pulse must match the oldest expected op.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data_out", 64'(data_out), 64'(e.dout));
        check("branch_flag", 64'(branch_flag), 64'(e.flg));
        check("out_valid_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic send(input int ch, input int s, input int d, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    ch_sel   = CW'(ch);
    sel      = 4'(s);
    data_in  = W'(d);
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_apply(ch, s, d);
    for (int k = 0; k < CH; k++) begin
      e.dout[k*W +: W] = W'(mD[k]);
      e.flg[k]         = mF[k][0];
    end
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((!in_ready || q.size() != 0) && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("drain_timeout", 64'(t < 100), 64'd1);
  endtask

  task automatic pv_check(input int ch, input int s, input int d);
    @(negedge clk);
    in_valid = 1'b0;
    ch_sel   = CW'(ch);
    sel      = 4'(s);
    data_in  = W'(d);
    #1;
    check("comb_preview", 64'(comb_preview), 64'(m_preview(ch, s, d)));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, w2, t;
    rst_n = 1'b0; in_valid = 1'b0; ch_sel = '0; sel = '0; data_in = '0;
    ch16 = '0; sel16 = '0; din16 = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_flag", 64'(branch_flag), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Preview from fresh reset, both widths.
    pv_check(0, 1, 0);
    check("preview_fresh_01", 64'(comb_preview), 64'h02);
    pv_check(0, 15, 0);
    check("preview_fresh_1111", 64'(comb_preview), 64'h3F);
    ch16 = 2'd0; sel16 = 4'b0001; din16 = 16'h0000; #1;
    check("preview16_01", 64'(pv16), 64'h0002);
    sel16 = 4'b1111; #1;
    check("preview16_1111", 64'(pv16), 64'h3F3F);

    // Directed sequences.
    send(1, 4'b1000, 8'h5A, w);
    wait_idle();
    check("ch1_op1_dout", 64'(data_out[15:8]), 64'h5A);
    check("ch1_op1_flag", 64'(branch_flag[1]), 64'd1);
    send(1, 4'b1001, 8'h12, w);
    wait_idle();
    check("ch1_op2_dout", 64'(data_out[15:8]), 64'h5F);
    check("ch1_others", 64'({data_out[31:16], data_out[7:0]}), 64'd0);
    pv_check(1, 3, 0);   // B masked by F=1: 0x12 & 0xF0
    check("ch1_buffer_view", 64'(comb_preview), 64'h10);
    send(2, 4'b0100, 8'h0F, w);
    wait_idle();
    check("ch2_dout", 64'(data_out[23:16]), 64'hF0);
    check("ch2_flag", 64'(branch_flag[2]), 64'd0);
    send(0, 4'b0000, 8'h77, w);
    wait_idle();
    check("ch0_sel0_dout", 64'(data_out[7:0]), 64'hAA);
    send(0, 4'b0001, 8'h01, w);
    wait_idle();
    check("ch0_sel1_dout", 64'(data_out[7:0]), 64'h01);
    check("ch0_sel1_flag", 64'(branch_flag[0]), 64'd1);
    pv_check(0, 0, 0);   // B=0x55 masked: 0x50
    check("ch0_buffer_view", 64'(comb_preview), 64'h50);

    // HOLD stall: second op held through it is accepted once.
    send(3, 4'b1111, $urandom_range(0, 255), w);
    send(2, 4'b0011, $urandom_range(0, 255), w2);
    check("stall_cycles", 64'(w2), 64'(1 + HC));
    wait_idle();

    // Randomized ops with preview checks in between.
    repeat (150) begin
      wait_idle();
      pv_check($urandom_range(0, CH-1), $urandom_range(0, 15), $urandom_range(0, 255));
      send($urandom_range(0, CH-1), $urandom_range(0, 15), $urandom_range(0, 255), w);
    end
    wait_idle();

    // Reset in the middle of HOLD.
    send(3, 4'b1111, $urandom_range(0, 255), w);
    t = 0;
    while (q.size() != 0 && t < 20) begin
      t++;
      @(negedge clk);
    end
    check("hold_pulse_seen", 64'(q.size()), 64'd0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    check("midhold_data_out", 64'(data_out), 64'd0);
    check("midhold_flag", 64'(branch_flag), 64'd0);
    check("midhold_in_ready", 64'(in_ready), 64'd1);
    check("midhold_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_idle", 64'(in_ready), 64'd1);
    pv_check(3, 1, 0);
    check("post_reset_preview", 64'(comb_preview), 64'h02);

    // A couple of ops after reset to confirm normal operation resumes.
    send(3, 4'b0000, 8'h00, w);
    send(3, 4'b1011, 8'h3C, w);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
